// File: rtl/hsv_core_commit_flush.sv
// ---------------------------------------------------------------------------
// hsv_core_commit_flush
//   Commit-side consumer of an execution unit's result channel. It retires
//   entries in order and, on a jump/redirect entry, drives the flush_req /
//   flush_ack handshake with every execution unit. It then issues a
//   single-cycle redirect to fetch.
//
//   Sequence for a jump entry:
//     IDLE -> FLUSH    flush_req=1 until every unit has acked at least once
//          -> DRAIN    wait until all acks are low again, so that stale acks
//                      cannot satisfy the next flush
//          -> REDIRECT redirect_valid pulse with the latched target
//          -> IDLE
//
// Ports
//   clk_core, rst_core_n      clock, async active-low reset
//   valid_i / ready_o         commit entry handshake (ready only in IDLE)
//   in_pc, in_jump, in_target commit entry payload, sampled on transfer
//   flush_req                 registered flush request to all units
//   flush_ack[NUM_UNITS]      per-unit flush acknowledge
//   retire_valid, retire_pc   one-cycle retire pulse and its PC
//   redirect_valid, redirect_pc one-cycle fetch redirect and its target
//   flush_timeout             sticky: a flush waited TIMEOUT_CYCLES cycles
// ---------------------------------------------------------------------------
module hsv_core_commit_flush #(
  parameter int NUM_UNITS      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk_core,
  input  logic                 rst_core_n,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [31:0]          in_pc,
  input  logic                 in_jump,
  input  logic [31:0]          in_target,
  output logic                 flush_req,
  input  logic [NUM_UNITS-1:0] flush_ack,
  output logic                 retire_valid,
  output logic [31:0]          retire_pc,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 flush_timeout
);

  // Counter is wide enough to hold TIMEOUT_CYCLES itself (saturation value).
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    DRAIN    = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        jump;
    logic [31:0] target;
  } entry_t;

  state_t               state;
  entry_t               entry;
  logic [NUM_UNITS-1:0] ack_mask;
  logic [NUM_UNITS-1:0] ack_seen;
  logic [CNT_W-1:0]     to_cnt;
  logic [31:0]          target_q;
  logic                 xfer;
  logic                 flush_start;
  logic                 acks_all;
  logic                 acks_none;

  assign entry       = '{pc: in_pc, jump: in_jump, target: in_target};
  assign ready_o     = (state == IDLE);
  assign xfer        = valid_i && ready_o;
  assign flush_start = xfer && entry.jump;

  // Per-unit ack tracking. A unit counts as acked once its ack has been seen
  // high in any FLUSH cycle, even if it drops again before the others catch
  // up. The current-cycle ack is OR-ed in so completion needs no extra cycle.
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
        ack_mask[u] <= 1'b0;
      end else if (flush_start) begin
        ack_mask[u] <= 1'b0;
      end else if (state == FLUSH && flush_ack[u]) begin
        ack_mask[u] <= 1'b1;
      end
    end

    assign ack_seen[u] = ack_mask[u] | flush_ack[u];
  end

  assign acks_all  = &ack_seen;
  assign acks_none = ~|flush_ack;

  // Main sequencer; all outputs except ready_o are registered here.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state          <= IDLE;
      flush_req      <= 1'b0;
      retire_valid   <= 1'b0;
      retire_pc      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_timeout  <= 1'b0;
      to_cnt         <= '0;
      target_q       <= '0;
    end else begin
      retire_valid   <= 1'b0;
      redirect_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            retire_valid <= 1'b1;
            retire_pc    <= entry.pc;
            if (entry.jump) begin
              target_q  <= entry.target;
              to_cnt    <= '0;
              flush_req <= 1'b1;
              state     <= FLUSH;
            end
          end
        end

        FLUSH: begin
          // Saturating wait counter; the flag is raised in the same edge
          // that brings the counter to TIMEOUT_CYCLES. The FSM keeps waiting
          // for the acks regardless.
          if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + ONE;
          end
          if (to_cnt >= TO_MAX - ONE) begin
            flush_timeout <= 1'b1;
          end
          if (acks_all) begin
            flush_req <= 1'b0;
            state     <= DRAIN;
          end
        end

        DRAIN: begin
          if (acks_none) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= target_q;
            state          <= REDIRECT;
          end
        end

        REDIRECT: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hsv_core_commit_flush.sv
// ---------------------------------------------------------------------------
// tb_hsv_core_commit_flush
//   Scoreboard bench. Each accepted entry pushes its expected retire (and, for
//   jumps, its expected redirect) with the cycle it must appear. The flush
//   timeline (flush_req, ready_o, flush_timeout, ack stimulus) is planned per
//   cycle from the protocol rules: flush ends in the cycle every unit has
//   acked at least once, the redirect follows the first all-low ack cycle
//   after that. A monitor on the falling edge compares everything.
// ---------------------------------------------------------------------------
module tb_hsv_core_commit_flush;
  localparam int NU = 4;
  localparam int TO = 8;
  localparam int NC = 8192;

  logic          clk_core = 1'b0;
  logic          rst_core_n = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [31:0]   in_pc = '0;
  logic          in_jump = 1'b0;
  logic [31:0]   in_target = '0;
  logic          flush_req;
  logic [NU-1:0] flush_ack = '0;
  logic          retire_valid;
  logic [31:0]   retire_pc;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          flush_timeout;

  hsv_core_commit_flush #(.NUM_UNITS(NU), .TIMEOUT_CYCLES(TO)) dut (
    .clk_core(clk_core), .rst_core_n(rst_core_n),
    .valid_i(valid_i), .ready_o(ready_o),
    .in_pc(in_pc), .in_jump(in_jump), .in_target(in_target),
    .flush_req(flush_req), .flush_ack(flush_ack),
    .retire_valid(retire_valid), .retire_pc(retire_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_timeout(flush_timeout)
  );

  always #5 clk_core = ~clk_core;

  int cyc = 0;
  always @(posedge clk_core) cyc <= cyc + 1;

  typedef struct { int at; logic [31:0] pc; } ev_t;
  ev_t ret_q[$];
  ev_t red_q[$];

  bit            exp_rdy [NC];
  bit            exp_fr  [NC];
  bit            exp_to  [NC];
  logic [NU-1:0] ack_plan[NC];

  int a_rise [NU];
  bit a_drop [NU];
  int a_extra[NU];

  int n_cmp = 0;
  int n_bad = 0;
  int next_free = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %b, expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_core);
    #1;
    flush_ack = (cyc < NC) ? ack_plan[cyc] : '0;
  endtask

  task automatic clear_from(int c0);
    for (int c = c0; c < NC; c++) begin
      exp_rdy[c]  = 1'b1;
      exp_fr[c]   = 1'b0;
      exp_to[c]   = 1'b0;
      ack_plan[c] = '0;
    end
  endtask

  task automatic ideal_acks();
    for (int i = 0; i < NU; i++) begin
      a_rise[i] = 2; a_drop[i] = 1'b0; a_extra[i] = 0;
    end
  endtask

  // Plan a flush for a jump accepted in cycle t, using a_rise/a_drop/a_extra:
  // unit i first acks at t+a_rise[i]; it either drops after one cycle or
  // holds until one cycle after flush_req falls, plus a_extra[i] cycles.
  task automatic plan_jump(int t, logic [31:0] tgt);
    int t_all, t_zero, hi_end;
    t_all = t;
    for (int i = 0; i < NU; i++)
      if (t + a_rise[i] > t_all) t_all = t + a_rise[i];
    for (int i = 0; i < NU; i++) begin
      hi_end = a_drop[i] ? t + a_rise[i] : t_all + 1 + a_extra[i];
      for (int c = t + a_rise[i]; c <= hi_end && c < NC; c++) ack_plan[c][i] = 1'b1;
    end
    t_zero = t_all + 1;
    while (t_zero < NC - 1 && ack_plan[t_zero] != '0) t_zero++;
    for (int c = t + 1; c <= t_all && c < NC; c++) exp_fr[c] = 1'b1;
    for (int c = t + 1; c <= t_zero + 1 && c < NC; c++) exp_rdy[c] = 1'b0;
    if (t_all - t >= TO)
      for (int c = t + 1 + TO; c < NC; c++) exp_to[c] = 1'b1;
    red_q.push_back('{t_zero + 1, tgt});
    next_free = t_zero + 2;
  endtask

  // Wait for the model's next IDLE cycle (optionally with junk valid_i while
  // busy), then present one entry for exactly one cycle.
  task automatic issue(logic [31:0] pc, bit jmp, logic [31:0] tgt, bit noise);
    while (cyc < next_free) begin
      valid_i   = noise && ($urandom_range(0, 1) == 1);
      in_pc     = $urandom;
      in_jump   = ($urandom_range(0, 1) == 1);
      in_target = $urandom;
      step();
    end
    valid_i = 1'b1; in_pc = pc; in_jump = jmp; in_target = tgt;
    ret_q.push_back('{cyc + 1, pc});
    if (jmp) plan_jump(cyc, tgt);
    else next_free = cyc + 1;
    step();
    valid_i = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    ev_t e;
    logic [31:0] last_ret, last_red;
    last_ret = '0; last_red = '0;
    forever begin
      @(negedge clk_core);
      if (!rst_core_n) begin
        last_ret = '0; last_red = '0;
      end else if (cyc < NC) begin
        chk1("ready_o", ready_o, exp_rdy[cyc]);
        chk1("flush_req", flush_req, exp_fr[cyc]);
        chk1("flush_timeout", flush_timeout, exp_to[cyc]);

        if (retire_valid) begin
          if (ret_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL retire_unexpected @cyc %0d: got pc %h, expected no retire", cyc, retire_pc);
          end else begin
            e = ret_q.pop_front();
            chk("retire_cycle", 32'(cyc), 32'(e.at));
            chk("retire_pc", retire_pc, e.pc);
            last_ret = e.pc;
          end
        end else begin
          if (ret_q.size() > 0 && ret_q[0].at <= cyc) begin
            chk1("retire_valid", retire_valid, 1'b1);
            void'(ret_q.pop_front());
          end
          chk("retire_pc_hold", retire_pc, last_ret);
        end

        if (redirect_valid) begin
          if (red_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL redirect_unexpected @cyc %0d: got pc %h, expected no redirect", cyc, redirect_pc);
          end else begin
            e = red_q.pop_front();
            chk("redirect_cycle", 32'(cyc), 32'(e.at));
            chk("redirect_pc", redirect_pc, e.pc);
            last_red = e.pc;
          end
        end else begin
          if (red_q.size() > 0 && red_q[0].at <= cyc) begin
            chk1("redirect_valid", redirect_valid, 1'b1);
            void'(red_q.pop_front());
          end
          chk("redirect_pc_hold", redirect_pc, last_red);
        end
      end
    end
  end

  initial begin : watchdog
    #(NC * 10 + 1000);
    $display("FAIL watchdog: cycle %0d reached limit %0d", cyc, NC);
    $fatal(1);
  end

  initial begin : stim
    clear_from(0);
    ideal_acks();

    // Reset state
    repeat (3) step();
    chk1("rst_ready_o", ready_o, 1'b1);
    chk1("rst_flush_req", flush_req, 1'b0);
    chk1("rst_retire_valid", retire_valid, 1'b0);
    chk1("rst_redirect_valid", redirect_valid, 1'b0);
    chk1("rst_flush_timeout", flush_timeout, 1'b0);
    chk("rst_retire_pc", retire_pc, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    rst_core_n = 1'b1;
    next_free = cyc;

    // Back-to-back non-jump entries
    issue(32'h100, 1'b0, 32'h0, 1'b0);
    issue(32'h104, 1'b0, 32'h0, 1'b0);
    issue(32'h108, 1'b0, 32'h0, 1'b0);

    // Nominal jump with ideal registered-ack units
    ideal_acks();
    issue(32'h200, 1'b1, 32'h8000_0040, 1'b0);

    // Staggered acks, unit 0 drops early
    ideal_acks();
    a_rise[0] = 2; a_rise[1] = 4; a_rise[2] = 4; a_rise[3] = 7;
    a_drop[0] = 1'b1;
    issue(32'h300, 1'b1, 32'h1234_5600, 1'b0);

    // Stale ack held through DRAIN, then a jump right after the redirect
    ideal_acks();
    a_extra[1] = 3;
    issue(32'h400, 1'b1, 32'h0000_4000, 1'b0);
    ideal_acks();
    a_rise[0] = 2; a_rise[1] = 2; a_rise[2] = 3; a_rise[3] = 5;
    issue(32'h500, 1'b1, 32'h0000_5000, 1'b0);

    // Randomized traffic, junk valid_i while busy
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NU; i++) begin
        a_rise[i]  = $urandom_range(2, 5);
        a_drop[i]  = ($urandom_range(0, 3) == 0);
        a_extra[i] = $urandom_range(0, 2);
      end
      issue($urandom & 32'hFFFF_FFFC, ($urandom_range(0, 3) == 0), $urandom, 1'b1);
    end

    // Unit 2 acks late: timeout raised, flush still completes normally
    ideal_acks();
    a_rise[2] = 20;
    issue(32'h600, 1'b1, 32'h0000_6000, 1'b0);
    ideal_acks();
    issue(32'h604, 1'b0, 32'h0, 1'b0);
    issue(32'h608, 1'b1, 32'h0000_6800, 1'b0);

    // Unit 2 never acks; reset mid-FLUSH
    ideal_acks();
    a_rise[2] = NC;
    issue(32'h700, 1'b1, 32'h0000_7000, 1'b0);
    repeat (11) step();
    chk1("pre_reset_flush_req", flush_req, 1'b1);
    clear_from(cyc);
    flush_ack = '0;
    ret_q.delete();
    red_q.delete();
    #1 rst_core_n = 1'b0;
    #1;
    chk1("async_rst_flush_req", flush_req, 1'b0);
    chk1("async_rst_ready_o", ready_o, 1'b1);
    chk1("async_rst_flush_timeout", flush_timeout, 1'b0);
    chk1("async_rst_redirect_valid", redirect_valid, 1'b0);
    step();
    step();
    rst_core_n = 1'b1;
    next_free = cyc;
    repeat (10) step();

    ideal_acks();
    issue(32'h800, 1'b0, 32'h0, 1'b0);
    issue(32'h804, 1'b1, 32'h0000_9000, 1'b0);
    repeat (10) step();

    chk1("retire_q_drained", ret_q.size() == 0, 1'b1);
    chk1("redirect_q_drained", red_q.size() == 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
